// File: rtl/dpd_bypass_ctrl.sv
// DPD output-mux / NN engine sequencer: fills the NN pipeline before selecting it and drains it after bypassing.
// Optional macro DPD_SWITCH_FRAME_ALIGN_EN adds sof_i so the select only flips on frame boundaries.
module dpd_bypass_ctrl #(
    parameter int NN_LATENCY  = 16,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wdpd_req_i,
    input  logic        nn_ready_i,
    input  logic        dac_vld_i,
`ifdef DPD_SWITCH_FRAME_ALIGN_EN
    input  logic        sof_i,
`endif
    output logic        nn_en_o,
    output logic        wdpd_sel_o,
    output logic [1:0]  state_o,
    output logic [15:0] switch_cnt_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        BYPASS = 2'd0,
        FILL   = 2'd1,
        ACTIVE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(NN_LATENCY - 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic             sync_meta;
    logic             sync_out;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_next;
    logic             req_q;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [15:0]      switch_cnt;
    logic [15:0]      switch_cnt_next;
    logic             err;
    logic             err_next;
    logic             nn_en;
    logic             wdpd_sel;
    logic             frame_ok;

`ifdef DPD_SWITCH_FRAME_ALIGN_EN
    assign frame_ok = dac_vld_i & sof_i;
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= wdpd_req_i;
            sync_out  <= sync_meta;
        end
    end

    // The hold count restarts on the edge the new value enters sync_out, so that
    // edge is already the first stable cycle: total latency is 2 + HOLD_CYCLES.
    always_comb begin
        hold_cnt_next = hold_cnt;
        if (sync_meta != sync_out) begin
            hold_cnt_next = '0;
        end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt_next = hold_cnt + ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_cnt <= '0;
            req_q    <= 1'b0;
        end else begin
            hold_cnt <= hold_cnt_next;
            if (hold_cnt_next == HOLD_MAX) begin
                req_q <= sync_meta;
            end
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        switch_cnt_next = switch_cnt;
        err_next        = err;
        case (state)
            BYPASS: begin
                if (req_q && nn_ready_i) begin
                    state_next = FILL;
                    cnt_next   = LAT_LOAD;
                end
            end
            FILL: begin
                if (!nn_ready_i) begin
                    state_next = BYPASS;
                    err_next   = 1'b1;
                end else if (!req_q) begin
                    state_next = BYPASS;
                end else if (dac_vld_i) begin
                    if (cnt == '0) begin
                        if (frame_ok) begin
                            state_next = ACTIVE;
                            if (switch_cnt != 16'hFFFF) begin
                                switch_cnt_next = switch_cnt + 16'd1;
                            end
                        end
                    end else begin
                        cnt_next = cnt - ONE;
                    end
                end
            end
            ACTIVE: begin
                // Losing the engine must bypass at once; a plain request drop may wait for a frame edge.
                if (!nn_ready_i) begin
                    state_next = DRAIN;
                    cnt_next   = LAT_LOAD;
                    err_next   = 1'b1;
                end else if (!req_q && frame_ok) begin
                    state_next = DRAIN;
                    cnt_next   = LAT_LOAD;
                end
            end
            DRAIN: begin
                if (dac_vld_i) begin
                    if (cnt == '0) begin
                        state_next = BYPASS;
                    end else begin
                        cnt_next = cnt - ONE;
                    end
                end
            end
            default: begin
                state_next = BYPASS;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= BYPASS;
            cnt        <= '0;
            switch_cnt <= '0;
            err        <= 1'b0;
            nn_en      <= 1'b0;
            wdpd_sel   <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            switch_cnt <= switch_cnt_next;
            err        <= err_next;
            nn_en      <= (state_next != BYPASS);
            wdpd_sel   <= (state_next == ACTIVE);
        end
    end

    assign nn_en_o      = nn_en;
    assign wdpd_sel_o   = wdpd_sel;
    assign state_o      = state;
    assign switch_cnt_o = switch_cnt;
    assign err_o        = err;

endmodule

// File: tb/tb_dpd_bypass_ctrl.sv
// Bench for dpd_bypass_ctrl: timeline-derived expectations pushed to a scoreboard and checked one cycle later.
// A second instance (NN_LATENCY=1, HOLD_CYCLES=1) covers the minimum-latency corner.
module tb_dpd_bypass_ctrl;

    localparam logic [1:0] S_BYP = 2'd0;
    localparam logic [1:0] S_FIL = 2'd1;
    localparam logic [1:0] S_ACT = 2'd2;
    localparam logic [1:0] S_DRN = 2'd3;

    typedef struct {
        logic        rst;
        logic        req;
        logic        ready;
        logic        vld;
        logic        sof;
        logic [1:0]  state;
        logic        en;
        logic        sel;
        logic        err;
        logic [15:0] sw;
        bit          on_b;
        int          phase;
        int          step;
    } vec_t;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic wdpd_req = 1'b0;
    logic nn_ready = 1'b0;
    logic dac_vld  = 1'b0;
`ifdef DPD_SWITCH_FRAME_ALIGN_EN
    logic sof      = 1'b1;
`endif

    logic        nn_en_a, sel_a, err_a;
    logic [1:0]  state_a;
    logic [15:0] sw_a;
    logic        nn_en_b, sel_b, err_b;
    logic [1:0]  state_b;
    logic [15:0] sw_b;

    int   n_vec     = 0;
    int   n_miss    = 0;
    int   cur_phase = 0;
    int   cur_step  = 0;
    vec_t sb[$];
    vec_t glitch_tbl[12];

    always #5 clk = ~clk;

    dpd_bypass_ctrl #(.NN_LATENCY(16), .HOLD_CYCLES(4), .CNT_W(8)) dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .wdpd_req_i   (wdpd_req),
        .nn_ready_i   (nn_ready),
        .dac_vld_i    (dac_vld),
`ifdef DPD_SWITCH_FRAME_ALIGN_EN
        .sof_i        (sof),
`endif
        .nn_en_o      (nn_en_a),
        .wdpd_sel_o   (sel_a),
        .state_o      (state_a),
        .switch_cnt_o (sw_a),
        .err_o        (err_a)
    );

    dpd_bypass_ctrl #(.NN_LATENCY(1), .HOLD_CYCLES(1), .CNT_W(8)) dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .wdpd_req_i   (wdpd_req),
        .nn_ready_i   (nn_ready),
        .dac_vld_i    (dac_vld),
`ifdef DPD_SWITCH_FRAME_ALIGN_EN
        .sof_i        (sof),
`endif
        .nn_en_o      (nn_en_b),
        .wdpd_sel_o   (sel_b),
        .state_o      (state_b),
        .switch_cnt_o (sw_b),
        .err_o        (err_b)
    );

    function automatic vec_t mk(input logic rst_v, input logic req_v, input logic ready_v,
                                input logic vld_v, input logic [1:0] st, input logic en_v,
                                input logic sel_v, input logic err_v, input logic [15:0] sw_v,
                                input bit b);
        vec_t v;
        v.rst   = rst_v;
        v.req   = req_v;
        v.ready = ready_v;
        v.vld   = vld_v;
        v.sof   = 1'b1;
        v.state = st;
        v.en    = en_v;
        v.sel   = sel_v;
        v.err   = err_v;
        v.sw    = sw_v;
        v.on_b  = b;
        v.phase = 0;
        v.step  = 0;
        return v;
    endfunction

    task automatic checkOutput();
        vec_t        e;
        logic [1:0]  a_st;
        logic        a_en, a_sel, a_err;
        logic [15:0] a_sw;
        n_vec++;
        if (sb.size() == 0) begin
            n_miss++;
            $display("[TB] FAIL scoreboard_empty: got 0 queued entries, required 1");
            return;
        end
        e = sb.pop_front();
        if (e.on_b) begin
            a_st = state_b; a_en = nn_en_b; a_sel = sel_b; a_err = err_b; a_sw = sw_b;
        end else begin
            a_st = state_a; a_en = nn_en_a; a_sel = sel_a; a_err = err_a; a_sw = sw_a;
        end
        if (a_st !== e.state || a_en !== e.en || a_sel !== e.sel || a_err !== e.err || a_sw !== e.sw) begin
            n_miss++;
            $display("[TB] FAIL p%0d.s%0d%s: got state=%0d en=%0b sel=%0b err=%0b sw=%0d, required state=%0d en=%0b sel=%0b err=%0b sw=%0d",
                     e.phase, e.step, e.on_b ? "(lat1)" : "", a_st, a_en, a_sel, a_err, a_sw,
                     e.state, e.en, e.sel, e.err, e.sw);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        v.phase = cur_phase;
        v.step  = cur_step;
        cur_step++;
        rst      = v.rst;
        wdpd_req = v.req;
        nn_ready = v.ready;
        dac_vld  = v.vld;
`ifdef DPD_SWITCH_FRAME_ALIGN_EN
        sof      = v.sof;
`endif
        sb.push_back(v);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic newPhase(input int p);
        cur_phase = p;
        cur_step  = 1;
    endtask

    initial begin
        for (int i = 0; i < 12; i++) begin
            glitch_tbl[i] = mk(1'b0, (i < 3), 1'b1, 1'b1, S_BYP, 1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
        end

        // Reset with the request already high.
        newPhase(1);
        repeat (2) applyStimulus(mk(1'b1, 1'b1, 1'b1, 1'b1, S_BYP, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0));

        // Enable: FILL on edge 2+4, select after 16 further valid beats.
        newPhase(2);
        for (int n = 1; n <= 24; n++) begin
            applyStimulus(mk(1'b0, 1'b1, 1'b1, 1'b1,
                             (n < 6) ? S_BYP : ((n < 22) ? S_FIL : S_ACT),
                             (n >= 6), (n >= 22), 1'b0, (n >= 22) ? 16'd1 : 16'd0, 1'b0));
        end

        // Disable: select drops on edge 6, engine drains 16 beats.
        newPhase(3);
        for (int m = 1; m <= 24; m++) begin
            applyStimulus(mk(1'b0, 1'b0, 1'b1, 1'b1,
                             (m < 6) ? S_ACT : ((m < 22) ? S_DRN : S_BYP),
                             (m < 22), (m < 6), 1'b0, 16'd1, 1'b0));
        end

        // Three-cycle request glitch is filtered.
        newPhase(4);
        for (int i = 0; i < 12; i++) applyStimulus(glitch_tbl[i]);

        // Fill with dac_vld toggling: 32 cycles in FILL.
        newPhase(5);
        for (int k = 1; k <= 39; k++) begin
            applyStimulus(mk(1'b0, 1'b1, 1'b1, (k < 7) ? 1'b1 : (k % 2 == 0),
                             (k < 6) ? S_BYP : ((k < 38) ? S_FIL : S_ACT),
                             (k >= 6), (k >= 38), 1'b0, (k >= 38) ? 16'd2 : 16'd1, 1'b0));
        end

        // nn_ready loss in ACTIVE, DRAIN holds without valids, re-request ignored until BYPASS.
        newPhase(6);
        for (int k = 1; k <= 48; k++) begin
            applyStimulus(mk(1'b0, (k >= 2 && k <= 10) ? 1'b0 : 1'b1, (k != 1),
                             (k == 1 || k >= 31),
                             (k < 46) ? S_DRN : ((k == 46) ? S_BYP : S_FIL),
                             (k != 46), 1'b0, 1'b1, 16'd2, 1'b0));
        end

        // Reset mid-FILL returns to BYPASS in one cycle and clears everything.
        newPhase(7);
        applyStimulus(mk(1'b1, 1'b1, 1'b1, 1'b1, S_BYP, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0));

        // nn_ready loss on fill beat 8 -> BYPASS with err, counter untouched, then refill.
        newPhase(8);
        for (int k = 1; k <= 23; k++) begin
            applyStimulus(mk(1'b0, 1'b1, (k != 22), (k < 7) ? 1'b1 : (k % 2 == 0),
                             (k < 6) ? S_BYP : ((k < 22) ? S_FIL : ((k == 22) ? S_BYP : S_FIL)),
                             (k >= 6 && k != 22), 1'b0, (k >= 22), 16'd0, 1'b0));
        end

        // Minimum latency instance: one-beat FILL and DRAIN, 3-cycle request latency.
        newPhase(9);
        applyStimulus(mk(1'b1, 1'b1, 1'b1, 1'b1, S_BYP, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1));
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(mk(1'b0, (k <= 4), 1'b1, 1'b1,
                             (k < 3) ? S_BYP : ((k == 3) ? S_FIL : ((k <= 6) ? S_ACT : ((k == 7) ? S_DRN : S_BYP))),
                             (k >= 3 && k <= 7), (k >= 4 && k <= 6), 1'b0,
                             (k >= 4) ? 16'd1 : 16'd0, 1'b1));
        end

`ifdef DPD_SWITCH_FRAME_ALIGN_EN
        // Frame aligned switching with sof every 64 beats.
        newPhase(10);
        applyStimulus(mk(1'b1, 1'b1, 1'b1, 1'b1, S_BYP, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0));
        for (int k = 1; k <= 140; k++) begin
            vec_t v;
            v = mk(1'b0, (k <= 70), 1'b1, 1'b1,
                   (k < 6) ? S_BYP : ((k < 64) ? S_FIL : ((k < 128) ? S_ACT : S_DRN)),
                   (k >= 6), (k >= 64 && k < 128), 1'b0, (k >= 64) ? 16'd1 : 16'd0, 1'b0);
            v.sof = (k % 64 == 0);
            applyStimulus(v);
        end
`endif

        if (sb.size() != 0) begin
            n_miss++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dpd_bypass_ctrl.md
Name: dpd_bypass_ctrl

Overview:
- Sequences the DPD output-mux select and the NN activation engine for the DAC path.
- On enable, the engine fills its pipeline before the mux switches, so the DAC never sees partial or garbage NN output.
- On disable, the mux returns to bypass at once and the engine then drains.
- Sits between the VIO DPD-enable request and the dpd_out select (vio_wdpd_i) of the in/out activation packer.

Parameters:
NN_LATENCY, 16, valid beats from inAct presented to matching outAct valid (1..255)
HOLD_CYCLES, 4, cycles the synced request must be stable before acting (1..255)
CNT_W, 8, width of the internal fill/drain/hold counters

Ports:
clk_i  input  1  datapath clock
rst_i  input  1  synchronous, active-high reset
wdpd_req_i  input  1  raw DPD-enable request from VIO, quasi-static
nn_ready_i  input  1  NN engine weights loaded and healthy
dac_vld_i  input  1  DAC sample-word valid beat (128-bit word advanced)
nn_en_o  output  1  NN engine clock-enable / run
wdpd_sel_o  output  1  mux select: 1 = NN output to DAC, 0 = bypass
state_o  output  2  0=BYPASS 1=FILL 2=ACTIVE 3=DRAIN
switch_cnt_o  output  16  completed BYPASS->ACTIVE transitions, saturating
err_o  output  1  sticky: nn_ready_i dropped while in FILL or ACTIVE

Behaviour:
- Reset (rst_i sampled high on clk_i edge): state BYPASS, nn_en_o=0, wdpd_sel_o=0, switch_cnt_o=0, err_o=0, synchronizer and counters cleared. Reset mid-switch is legal and returns to BYPASS in one cycle.
- wdpd_req_i goes through a 2-FF synchronizer, then debounce.
- req_q updates to the synced value only after that value has been stable HOLD_CYCLES consecutive cycles. Any change restarts the count.
- Request-to-action latency is 2 + HOLD_CYCLES cycles.
- All outputs are registered; they are functions of the registered state plus registered flags.
- BYPASS: nn_en_o=0, sel=0.
  - req_q=1 and nn_ready_i=1 -> FILL; counter loads NN_LATENCY-1.
  - req_q=1 with nn_ready_i=0 -> stay in BYPASS; err_o is not set.
- FILL: nn_en_o=1, sel=0.
  - Counter decrements only on dac_vld_i=1.
  - dac_vld_i=1 with counter=0 -> ACTIVE; sel=1 from the next cycle; switch_cnt_o increments, saturating at 0xFFFF.
  - req_q=0 -> BYPASS next cycle, nn_en_o=0, no drain needed.
  - nn_ready_i=0 -> BYPASS and err_o set. Priority: nn_ready_i loss > req_q drop > fill complete.
- ACTIVE: nn_en_o=1, sel=1.
  - req_q=0 or nn_ready_i=0 -> DRAIN; sel=0 on the same edge the state changes.
  - nn_ready_i=0 also sets err_o.
  - Counter loads NN_LATENCY-1.
- DRAIN: nn_en_o=1, sel=0.
  - Counter decrements on dac_vld_i.
  - dac_vld_i=1 with counter=0 -> BYPASS.
  - req_q changes are ignored until BYPASS is reached; re-enable then re-runs FILL.
- No dac_vld_i: FILL and DRAIN hold indefinitely. No timeout.
- err_o clears only on rst_i.
- NN_LATENCY=1: FILL and DRAIN each last exactly one valid beat.

Optional Feature:
DPD_SWITCH_FRAME_ALIGN_EN
- Defined:
  - Adds input port sof_i (1 bit), the frame start marker, qualified by dac_vld_i.
  - When the FILL counter reaches 0, FILL is held until a beat with dac_vld_i=1 and sof_i=1; that beat moves to ACTIVE.
  - ACTIVE->DRAIN on req_q drop likewise waits for sof_i&dac_vld_i. Loss of nn_ready_i still exits ACTIVE immediately.
  - Result: the select flips only on frame boundaries.
- Undefined: sof_i is absent and transitions are as described above.

Test Plan:
1. Reset with wdpd_req_i=1 held, nn_ready_i=1, dac_vld_i=1 every cycle, NN_LATENCY=16, HOLD_CYCLES=4 -> state FILL at cycle 2+4 after reset release; sel=1 exactly 16 valid beats later; switch_cnt_o=1.
2. In ACTIVE, drop wdpd_req_i -> sel=0 at cycle 6 after the drop, state DRAIN; nn_en_o=0 and BYPASS after 16 further valid beats.
3. wdpd_req_i glitch high for 3 cycles, HOLD_CYCLES=4 -> no state change, nn_en_o stays 0.
4. In FILL, dac_vld_i toggling 1/0 -> 32 cycles to ACTIVE. Drop nn_ready_i at fill beat 8 -> BYPASS next cycle, err_o=1, switch_cnt_o unchanged.
5. In ACTIVE, drop nn_ready_i -> sel=0 next edge, DRAIN, err_o=1. Re-request during DRAIN is ignored; FILL restarts only after BYPASS is reached.
6. With DPD_SWITCH_FRAME_ALIGN_EN and sof_i every 64 beats -> the sel 0->1 edge coincides with the beat after an sof_i beat, never between frames.
